// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the two-port BRAM arbiter.
// Holds the ownership state encoding and default widths.
package bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_MAX_LOCK   = 8;
  localparam int LOCK_CNT_W     = 8;

  function automatic arb_state_t own_state(
    input logic i_sel
  );
    return i_sel ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/bram_arbiter_rr_pick2.sv
// Two-way round-robin pick: favours the requester
// that was not granted most recently.
module rr_pick2
  import bram_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_sel
);

  always_comb begin
    o_valid = i_req0 | i_req1;
    o_sel   = 1'b0;
    unique case ({i_req1, i_req0})
      2'b01:   o_sel = 1'b0;
      2'b10:   o_sel = 1'b1;
      2'b11:   o_sel = ~i_last;
      default: o_sel = 1'b0;
    endcase
  end

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester arbiter in front of a single BRAM port,
// with round-robin ties and bounded ownership locking.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_LOCK   = DEF_MAX_LOCK
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam logic [LOCK_CNT_W-1:0] LP_MAX =
    LOCK_CNT_W'(MAX_LOCK);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic                  r_last;
  logic                  w_last_nxt;
  logic [LOCK_CNT_W-1:0] r_lock_cnt;
  logic [LOCK_CNT_W-1:0] w_lock_cnt_nxt;
  logic [LOCK_CNT_W-1:0] w_cnt_inc;
  logic                  r_rvalid0;
  logic                  r_rvalid1;

  logic w_pick_vld;
  logic w_pick_sel;
  logic w_gnt_vld;
  logic w_gnt_sel;
  logic w_sel_lock;
  logic w_sel_we;

  rr_pick2 u_pick (
    .i_req0  (req0),
    .i_req1  (req1),
    .i_last  (r_last),
    .o_valid (w_pick_vld),
    .o_sel   (w_pick_sel)
  );

  // Grant decode: an owner is served alone, else round-robin.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_sel = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_gnt_vld = w_pick_vld;
        w_gnt_sel = w_pick_sel;
      end
      OWN0: begin
        w_gnt_vld = req0;
        w_gnt_sel = 1'b0;
      end
      OWN1: begin
        w_gnt_vld = req1;
        w_gnt_sel = 1'b1;
      end
      default: begin
        w_gnt_vld = 1'b0;
        w_gnt_sel = 1'b0;
      end
    endcase
    if (reset) begin
      w_gnt_vld = 1'b0;
    end
  end

  assign w_sel_lock = w_gnt_sel ? lock1 : lock0;
  assign w_sel_we   = w_gnt_sel ? we1   : we0;
  assign w_cnt_inc  = r_lock_cnt + 1'b1;

  // Next state: ownership is kept only while locked and under limit.
  always_comb begin
    w_state_nxt    = IDLE;
    w_lock_cnt_nxt = '0;
    w_last_nxt     = r_last;
    if (w_gnt_vld) begin
      w_last_nxt = w_gnt_sel;
      if (w_sel_lock && (w_cnt_inc < LP_MAX)) begin
        w_state_nxt    = own_state(w_gnt_sel);
        w_lock_cnt_nxt = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt_vld & ~w_gnt_sel & ~w_sel_we;
      r_rvalid1 <= w_gnt_vld &  w_gnt_sel & ~w_sel_we;
    end
  end

  assign gnt0 = w_gnt_vld & ~w_gnt_sel;
  assign gnt1 = w_gnt_vld &  w_gnt_sel;

  assign mem_we   = w_gnt_vld & w_sel_we;
  assign mem_addr = !w_gnt_vld ? '0 :
                    (w_gnt_sel ? addr1 : addr0);
  assign mem_data = !w_gnt_vld ? '0 :
                    (w_gnt_sel ? wdata1 : wdata0);

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = (r_rvalid0 | r_rvalid1) ? mem_q : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: a behavioural BRAM, an
// arbitration reference model and a decoupled read-data monitor.
module tb_bram_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic [DW-1:0] mem_q;

  bram_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_LOCK   (ML)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .lock0    (lock0),
    .lock1    (lock1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_we   (mem_we),
    .mem_q    (mem_q)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return DW'(a * 16'h9E37) ^ 16'h1357;
  endfunction

  // Behavioural BRAM: registered read, write-first.
  logic [DW-1:0] bram [0:65535];
  bit            bram_wr [0:65535];

  always @(posedge clk) begin
    if (mem_we) begin
      bram[mem_addr]    <= mem_data;
      bram_wr[mem_addr] <= 1'b1;
      mem_q             <= mem_data;
    end else begin
      mem_q <= bram_wr[mem_addr] ? bram[mem_addr]
                                 : init_val(mem_addr);
    end
  end

  // Reference contents seen by the requesters, kept separately.
  logic [DW-1:0] refm [logic [AW-1:0]];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return refm.exists(a) ? refm[a] : init_val(a);
  endfunction

  typedef struct {
    int            who;
    logic [DW-1:0] data;
    int            cyc;
  } rd_t;

  rd_t sq[$];

  int m_owner  = -1;
  int m_streak = 0;
  int m_last   = 1;

  // Reference model: ownership, streak and round-robin rules.
  always @(negedge clk) begin
    int            g;
    logic [1:0]    rq, wq, lq;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    rd_t           e;
    rq = {req1, req0};
    wq = {we1, we0};
    lq = {lock1, lock0};
    if (reset) begin
      m_owner  = -1;
      m_streak = 0;
      m_last   = 1;
      sq.delete();
      chk("rst_out", 64'({gnt1, gnt0, mem_we, mem_addr, mem_data}),
          64'd0);
    end else begin
      if (m_owner >= 0) g = rq[m_owner] ? m_owner : -1;
      else if (rq == 2'b11) g = 1 - m_last;
      else if (rq[0]) g = 0;
      else if (rq[1]) g = 1;
      else g = -1;
      chk("gnt", 64'({gnt1, gnt0}),
          64'(g < 0 ? 2'b00 : (g == 1 ? 2'b10 : 2'b01)));
      if (g < 0) begin
        chk("mem_idle", 64'({mem_we, mem_addr, mem_data}), 64'd0);
        m_owner  = -1;
        m_streak = 0;
      end else begin
        a = (g == 1) ? addr1 : addr0;
        d = (g == 1) ? wdata1 : wdata0;
        chk("mem_port", 64'({mem_we, mem_addr, mem_data}),
            64'({wq[g], a, d}));
        if (wq[g]) begin
          refm[a] = d;
        end else begin
          e.who  = g;
          e.data = ref_rd(a);
          e.cyc  = cyc + 1;
          sq.push_back(e);
        end
        m_last = g;
        if (lq[g]) begin
          m_streak++;
          if (m_streak >= ML) begin
            m_owner  = -1;
            m_streak = 0;
          end else begin
            m_owner = g;
          end
        end else begin
          m_owner  = -1;
          m_streak = 0;
        end
      end
    end
  end

  logic g_seen [2];

  // Monitor: compares read returns against the scoreboard.
  always @(negedge clk) begin
    logic [1:0]    exp_rv;
    logic [DW-1:0] exp_d;
    rd_t           e;
    g_seen[0] = gnt0;
    g_seen[1] = gnt1;
    chk("excl", 64'(gnt0 & gnt1), 64'd0);
    exp_rv = 2'b00;
    exp_d  = '0;
    if (!reset && sq.size() > 0 && sq[0].cyc == cyc) begin
      e      = sq.pop_front();
      exp_rv = (e.who == 1) ? 2'b10 : 2'b01;
      exp_d  = e.data;
    end
    chk("rvalid", 64'({rvalid1, rvalid0}), 64'(exp_rv));
    chk("rdata", 64'(rdata), 64'(exp_d));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic w, input logic l,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic l,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
  endtask

  logic          c_req  [2];
  logic          c_we   [2];
  logic          c_lock [2];
  logic [AW-1:0] c_addr [2];
  logic [DW-1:0] c_data [2];

  initial begin
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // single read of a preloaded word by requester 0
    set0(1, 0, 0, 16'h0010, '0);
    tick();
    set0(0, 0, 0, '0, '0);
    repeat (3) tick();

    // both reading continuously: grants alternate
    set0(1, 0, 0, 16'h0020, '0);
    set1(1, 0, 0, 16'h0030, '0);
    repeat (6) tick();
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);
    repeat (2) tick();

    // locked owner is forced off after ML grants
    set0(1, 0, 1, 16'h0021, '0);
    set1(1, 0, 0, 16'h0031, '0);
    repeat (7) tick();
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);
    repeat (2) tick();

    // write by 1 then read of same word by 0
    set1(1, 1, 0, 16'h0040, 16'h1234);
    tick();
    set1(0, 0, 0, '0, '0);
    set0(1, 0, 0, 16'h0040, '0);
    tick();
    set0(0, 0, 0, '0, '0);
    repeat (3) tick();

    // reset in the middle of a locked stream
    set0(1, 0, 1, 16'h0050, '0);
    set1(1, 0, 0, 16'h0060, '0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    set0(1, 0, 0, 16'h0050, '0);
    tick();
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);
    repeat (3) tick();

    // randomized traffic, ungranted requests held stable
    for (int n = 0; n < 2; n++) c_req[n] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!c_req[n] || g_seen[n]) begin
          c_req[n]  = ($urandom_range(0, 3) != 0);
          c_we[n]   = ($urandom_range(0, 2) == 0);
          c_lock[n] = ($urandom_range(0, 3) == 0);
          c_addr[n] = AW'(16'h0040 + $urandom_range(0, 15));
          c_data[n] = DW'($urandom);
        end
      end
      set0(c_req[0], c_we[0], c_lock[0], c_addr[0], c_data[0]);
      set1(c_req[1], c_we[1], c_lock[1], c_addr[1], c_data[1]);
      reset = ($urandom_range(0, 249) == 0);
      tick();
    end
    reset = 1'b0;
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);
    repeat (4) tick();
    chk("drain", 64'(sq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width of BRAM port and requesters.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, address width of BRAM port and requesters.
REQ-003 SHALL have parameter MAX_LOCK, default 8, maximum consecutive locked grants before forced release (range 1..255).
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  requester n wants one access this cycle.
- we0 / we1  in  1  requester n access is a write.
- lock0 / lock1  in  1  requester n asks to keep ownership next cycle.
- addr0 / addr1  in  ADDR_WIDTH  requester n word address.
- wdata0 / wdata1  in  DATA_WIDTH  requester n write data.
- gnt0 / gnt1  out  1  requester n access accepted this cycle (combinational).
- rvalid0 / rvalid1  out  1  read data for requester n valid this cycle (registered).
- rdata  out  DATA_WIDTH  read data, shared; qualified by rvalid0/rvalid1.
- mem_addr  out  ADDR_WIDTH  to BRAM port address.
- mem_data  out  DATA_WIDTH  to BRAM port write data.
- mem_we  out  1  to BRAM port write enable.
- mem_q  in  DATA_WIDTH  from BRAM port registered read data (1-cycle latency).

Function
REQ-005 SHALL grant at most one requester per cycle; gnt0 and gnt1 never both 1.
REQ-006 SHALL assert gntn in the same cycle reqn is sampled if n wins; an ungranted requester holds req/we/addr/wdata stable until granted.
REQ-007 SHALL drive mem_addr/mem_data/mem_we combinationally from the winner; with no grant, mem_we=0, mem_addr/mem_data=0.
REQ-008 SHALL, for a granted read in cycle N, assert rvalidn for exactly cycle N+1 with rdata=mem_q; rdata=0 when neither rvalid asserted.
REQ-009 SHALL NOT assert rvalid for granted writes.
REQ-010 SHALL use FSM states IDLE, OWN0, OWN1 (registered).
REQ-011 IDLE: one requester -> grant it; both -> grant the one not granted last (round-robin pointer last_gnt); none -> no grant.
REQ-012 Grant to n with lockn=1 -> next state OWNn, lock_cnt increments; grant with lockn=0 -> next state IDLE, lock_cnt=0.
REQ-013 OWNn: grant n whenever reqn=1, regardless of other requester; reqn=0 -> no grant this cycle, return to IDLE, lock_cnt=0.
REQ-014 OWNn: when lock_cnt reaches MAX_LOCK, next state SHALL be IDLE and last_gnt=n, so a waiting other requester wins next cycle.
REQ-015 last_gnt SHALL update to n on every grant to n.
REQ-016 Back-to-back grants SHALL sustain one access per cycle; read data pipeline SHALL not stall or drop rvalid across owner change.
REQ-017 Same-address write then read by different requesters in consecutive cycles SHALL return the newly written value (BRAM write-first order preserved by strict serialisation).

Reset
REQ-018 reset=1 SHALL immediately force: state IDLE, last_gnt=1 (requester 0 wins first tie), lock_cnt=0, rvalid0=rvalid1=0, rdata=0.
REQ-019 gnt/mem_* outputs SHALL be 0 while reset=1; a read granted the cycle before reset asserts SHALL produce no rvalid.

Structure
REQ-020 Shared package bram_arb_pkg SHALL hold the state enum (IDLE, OWN0, OWN1) and default width constants (16/16) and MAX_LOCK default.
REQ-021 SHALL instantiate one sub-module rr_pick2: combinational 2-way round-robin pick from req0, req1, last_gnt.

Verification
REQ-022 Reset, then req0=1 read addr 0x0010 (mem holds 0xBEEF), req1=0 -> gnt0 cycle 1, rvalid0=1, rdata=0xBEEF cycle 2, gnt1 never.
REQ-023 req0, req1 both reads held 6 cycles -> grants alternate 0,1,0,1,0,1; each rvalid one cycle after its grant.
REQ-024 req0 lock0=1 held with MAX_LOCK=4, req1 held -> gnt0 for 4 cycles, then gnt1; no overlap.
REQ-025 Cycle N req1 writes 0x1234 to 0x0040; cycle N+1 req0 reads 0x0040 -> rvalid0 at N+2 with rdata=0x1234; no rvalid1.
REQ-026 Reset asserted mid-stream (both requesting, OWN0 active) -> all outputs 0 same cycle; after release, first tie grants requester 0.
